// File: rtl/rau_pkg.sv
// rtl/rau_pkg.sv - shared types and default constants for the register allocation unit
//
// Purpose : FSM state encoding, LUT entry layout and default parameter values
//           shared by the allocation map, its interface and its sub-modules.
// Ports   : none (package)
package rau_pkg;

   localparam int DEF_NUM_WARPS = 8;
   localparam int DEF_LREGS     = 8;
   localparam int DEF_NUM_BANKS = 4;
   localparam int DEF_NUM_ROWS  = 8;
   localparam int DEF_NUM_OC    = 4;

   // Slot index width for the default geometry (rows * bank pairs).
   localparam int RAU_SLOT_W = $clog2(DEF_NUM_ROWS * DEF_NUM_BANKS / 2);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ALLOC   = 2'd1,
      ST_DEALLOC = 2'd2
   } rau_state_e;

   typedef struct packed {
      logic                  valid;
      logic [RAU_SLOT_W-1:0] slot;
   } lut_entry_t;

endpackage

// File: rtl/rau_alloc_map_if.sv
// rtl/rau_alloc_map_if.sv - request/translation bus of the register allocation map
//
// Purpose : bundles the allocation, exit, read/write translation and operand
//           collector select signals.
// Modports: master - requester side (drives requests, observes results)
//           slave  - allocation map side
interface rau_alloc_map_if
   import rau_pkg::*;
#(
   parameter int NUM_WARPS = DEF_NUM_WARPS,
   parameter int LREGS     = DEF_LREGS,
   parameter int NUM_BANKS = DEF_NUM_BANKS,
   parameter int NUM_ROWS  = DEF_NUM_ROWS,
   parameter int NUM_OC    = DEF_NUM_OC
) ();

   localparam int WW    = $clog2(NUM_WARPS);
   localparam int RW    = $clog2(LREGS);
   localparam int SRCW  = RW + 1;
   localparam int BW    = $clog2(NUM_BANKS);
   localparam int ROWW  = $clog2(NUM_ROWS);
   localparam int NSLOT = NUM_ROWS * NUM_BANKS / 2;
   localparam int FSW   = $clog2(NSLOT) + 1;

   logic              alloc_valid;
   logic              alloc_ready;
   logic [WW-1:0]     alloc_warp;
   logic [RW:0]       alloc_nreg;
   logic [7:0]        alloc_swid;
   logic              alloc_done;
   logic              alloc_err;

   logic              exit_valid;
   logic [WW-1:0]     exit_warp;
   logic [FSW-1:0]    free_slots;

   logic [WW-1:0]     rd_warp;
   logic [2*SRCW-1:0] rd_src;
   logic [1:0]        rd_en;
   logic [2*BW-1:0]   rd_bank;
   logic [2*ROWW-1:0] rd_row;
   logic [1:0]        rd_ok;
   logic              rd_conflict;

   logic              wr_en;
   logic [WW-1:0]     wr_warp;
   logic [RW-1:0]     wr_reg;
   logic [BW-1:0]     wr_bank;
   logic [ROWW-1:0]   wr_row;
   logic              wr_ok;

   logic [NUM_OC-1:0] oc_empty;
   logic [NUM_OC-1:0] oc_sel;
   logic [31:0]       special_data;

   modport master (
      output alloc_valid, alloc_warp, alloc_nreg, alloc_swid,
      output exit_valid, exit_warp,
      output rd_warp, rd_src, rd_en,
      output wr_en, wr_warp, wr_reg,
      output oc_empty,
      input  alloc_ready, alloc_done, alloc_err, free_slots,
      input  rd_bank, rd_row, rd_ok, rd_conflict,
      input  wr_bank, wr_row, wr_ok,
      input  oc_sel, special_data
   );

   modport slave (
      input  alloc_valid, alloc_warp, alloc_nreg, alloc_swid,
      input  exit_valid, exit_warp,
      input  rd_warp, rd_src, rd_en,
      input  wr_en, wr_warp, wr_reg,
      input  oc_empty,
      output alloc_ready, alloc_done, alloc_err, free_slots,
      output rd_bank, rd_row, rd_ok, rd_conflict,
      output wr_bank, wr_row, wr_ok,
      output oc_sel, special_data
   );

endinterface

// File: rtl/rau_free_pick.sv
// rtl/rau_free_pick.sv - lowest-index free slot priority encoder
//
// Purpose : scans the slot occupancy map and returns the lowest free slot.
// Ports   : used_i  - occupancy map, bit set = slot taken
//           found_o - at least one slot is free
//           idx_o   - index of the lowest free slot (0 when none)
module rau_free_pick #(
   parameter  int NSLOT = 16,
   localparam int SLW   = $clog2(NSLOT)
) (
   input  logic [NSLOT-1:0] used_i,
   output logic             found_o,
   output logic [SLW-1:0]   idx_o
);

   // Descending scan so the lowest free index is the last one written.
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      for (int s = NSLOT - 1; s >= 0; s--) begin
         if (!used_i[s]) begin
            found_o = 1'b1;
            idx_o   = SLW'(s);
         end
      end
   end

endmodule

// File: rtl/rau_alloc_map.sv
// rtl/rau_alloc_map.sv - per-warp logical-to-physical register slot allocation map
//
// Purpose : allocates register slots (two adjacent banks of one row) to warps,
//           frees them on warp exit, and translates logical register reads and
//           writes into physical bank/row coordinates. Also selects the lowest
//           empty operand collector.
// Ports   : clk        - clock
//           rst        - asynchronous active-high reset
//           bus        - rau_alloc_map_if.slave (alloc/exit/translate/oc signals)
// Config  : RAU_SPECIAL_REG_EN - per-warp special register (software warp ID)
//           readable through a source operand with its MSB set.
module rau_alloc_map
   import rau_pkg::*;
#(
   parameter int NUM_WARPS = DEF_NUM_WARPS,
   parameter int LREGS     = DEF_LREGS,
   parameter int NUM_BANKS = DEF_NUM_BANKS,
   parameter int NUM_ROWS  = DEF_NUM_ROWS,
   parameter int NUM_OC    = DEF_NUM_OC
) (
   input  logic          clk,
   input  logic          rst,
   rau_alloc_map_if.slave bus
);

   localparam int WW    = $clog2(NUM_WARPS);
   localparam int RW    = $clog2(LREGS);
   localparam int NW    = RW + 1;
   localparam int SRCW  = RW + 1;
   localparam int MAXS  = LREGS / 2;
   localparam int MW    = $clog2(MAXS);
   localparam int BW    = $clog2(NUM_BANKS);
   localparam int HB    = $clog2(NUM_BANKS / 2);
   localparam int ROWW  = $clog2(NUM_ROWS);
   localparam int NSLOT = NUM_ROWS * NUM_BANKS / 2;
   localparam int SLW   = $clog2(NSLOT);
   localparam int FSW   = SLW + 1;

   typedef struct packed {
      logic            ok;
      logic [BW-1:0]   bank;
      logic [ROWW-1:0] row;
   } xlat_t;

   rau_state_e       state_q, state_d;
   lut_entry_t       lut_q [NUM_WARPS][MAXS];
   logic [NSLOT-1:0] used_q;
   logic [FSW-1:0]   free_cnt_q;
   logic [WW-1:0]    warp_q;
   logic [MW-1:0]    k_q;
   logic [NW-1:0]    rem_q;
   logic [WW-1:0]    exit_warp_q;
   logic             done_q;
   logic             err_q;

   logic             accept;
   logic             grant;
   logic             dealloc;
   logic             ready_c;
   logic             alloc_bad;
   logic             warp_busy;
   logic [NW-1:0]    need;
   logic [FSW-1:0]   dealloc_cnt;
   logic             pick_found;
   logic [SLW-1:0]   pick_idx;

   rau_free_pick #(.NSLOT(NSLOT)) u_free_pick (
      .used_i  (used_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   // ceil(nreg/2) without overflowing the nreg width.
   assign need = {1'b0, bus.alloc_nreg[RW:1]} + NW'(bus.alloc_nreg[0]);

   always_comb begin
      warp_busy = 1'b0;
      for (int k = 0; k < MAXS; k++) begin
         warp_busy = warp_busy | lut_q[bus.alloc_warp][k].valid;
      end
   end

   assign alloc_bad = warp_busy || (int'(need) > MAXS) || (need == '0);

   always_comb begin
      dealloc_cnt = '0;
      for (int k = 0; k < MAXS; k++) begin
         if (lut_q[exit_warp_q][k].valid) begin
            dealloc_cnt = dealloc_cnt + FSW'(1);
         end
      end
   end

   // Control FSM: exit requests take precedence over allocation in IDLE.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      grant   = 1'b0;
      dealloc = 1'b0;
      ready_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            ready_c = !bus.exit_valid && (int'(free_cnt_q) >= int'(need));
            if (bus.exit_valid) begin
               state_d = ST_DEALLOC;
            end else if (bus.alloc_valid && ready_c) begin
               accept = 1'b1;
               // Rejected requests are consumed but leave the FSM in IDLE.
               if (!alloc_bad) begin
                  state_d = ST_ALLOC;
               end
            end
         end
         ST_ALLOC: begin
            grant = pick_found;
            if (rem_q <= NW'(1)) begin
               state_d = ST_IDLE;
            end
         end
         ST_DEALLOC: begin
            dealloc = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lut_q       <= '{default: '0};
         used_q      <= '0;
         free_cnt_q  <= FSW'(NSLOT);
         warp_q      <= '0;
         k_q         <= '0;
         rem_q       <= '0;
         exit_warp_q <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;

         if (state_q == ST_IDLE && bus.exit_valid) begin
            exit_warp_q <= bus.exit_warp;
         end

         if (accept) begin
            if (alloc_bad) begin
               err_q <= 1'b1;
            end else begin
               warp_q <= bus.alloc_warp;
               k_q    <= '0;
               rem_q  <= need;
            end
         end

         if (grant) begin
            lut_q[warp_q][k_q] <= '{valid: 1'b1, slot: RAU_SLOT_W'(pick_idx)};
            used_q[pick_idx]   <= 1'b1;
            free_cnt_q         <= free_cnt_q - FSW'(1);
            k_q                <= k_q + MW'(1);
            rem_q              <= rem_q - NW'(1);
            // Registered here so the pulse lands in the cycle after the last grant.
            if (rem_q == NW'(1)) begin
               done_q <= 1'b1;
            end
         end

         if (dealloc) begin
            for (int k = 0; k < MAXS; k++) begin
               if (lut_q[exit_warp_q][k].valid) begin
                  lut_q[exit_warp_q][k].valid                 <= 1'b0;
                  used_q[SLW'(lut_q[exit_warp_q][k].slot)]    <= 1'b0;
               end
            end
            free_cnt_q <= free_cnt_q + dealloc_cnt;
         end
      end
   end

   // Slot s lives in row s/(NUM_BANKS/2); the register LSB picks the bank of the pair.
   function automatic xlat_t xlat(input lut_entry_t ent, input logic en, input logic lsb);
      xlat_t          r;
      logic [SLW-1:0] slot;
      r    = '0;
      slot = SLW'(ent.slot);
      if (en && ent.valid) begin
         r.ok   = 1'b1;
         r.row  = slot[SLW-1:HB];
         r.bank = {slot[HB-1:0], lsb};
      end
      return r;
   endfunction

   logic [SRCW-1:0] src0, src1;
   logic            spec0, spec1;
   xlat_t           x0, x1, xw;

   assign src0  = bus.rd_src[SRCW-1:0];
   assign src1  = bus.rd_src[2*SRCW-1:SRCW];
   assign spec0 = src0[SRCW-1];
   assign spec1 = src1[SRCW-1];

   // Special operands never consult the LUT, so they carry no bank/row.
   assign x0 = xlat(lut_q[bus.rd_warp][src0[RW-1:1]], bus.rd_en[0] & ~spec0, src0[0]);
   assign x1 = xlat(lut_q[bus.rd_warp][src1[RW-1:1]], bus.rd_en[1] & ~spec1, src1[0]);
   assign xw = xlat(lut_q[bus.wr_warp][bus.wr_reg[RW-1:1]], bus.wr_en, bus.wr_reg[0]);

   assign bus.rd_bank     = {x1.bank, x0.bank};
   assign bus.rd_row      = {x1.row, x0.row};
   assign bus.rd_conflict = x0.ok & x1.ok & (x0.bank == x1.bank);
   assign bus.wr_bank     = xw.bank;
   assign bus.wr_row      = xw.row;
   assign bus.wr_ok       = xw.ok;

`ifdef RAU_SPECIAL_REG_EN
   logic [7:0] special_q [NUM_WARPS];
   logic       sh0, sh1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         special_q <= '{default: '0};
      end else if (accept && !alloc_bad) begin
         special_q[bus.alloc_warp] <= bus.alloc_swid;
      end
   end

   assign sh0              = bus.rd_en[0] & spec0;
   assign sh1              = bus.rd_en[1] & spec1;
   assign bus.rd_ok        = {x1.ok | sh1, x0.ok | sh0};
   assign bus.special_data = (sh0 | sh1) ? {24'd0, special_q[bus.rd_warp]} : 32'd0;
`else
   logic unused_swid;

   assign unused_swid      = ^bus.alloc_swid;
   assign bus.rd_ok        = {x1.ok, x0.ok};
   assign bus.special_data = 32'd0;
`endif

   // Isolate the lowest set bit of the empty mask.
   assign bus.oc_sel      = bus.oc_empty & (~bus.oc_empty + NUM_OC'(1));

   assign bus.alloc_ready = ready_c;
   assign bus.alloc_done  = done_q;
   assign bus.alloc_err   = err_q;
   assign bus.free_slots  = free_cnt_q;

endmodule

// File: tb/tb_rau_alloc_map.sv
// tb/tb_rau_alloc_map.sv - directed self-checking bench for rau_alloc_map
module tb_rau_alloc_map;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   rau_alloc_map_if bus ();

   rau_alloc_map dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge where alloc_done is seen.
   task automatic do_alloc(input logic [2:0] w, input logic [3:0] n, output bit ok);
      ok = 1'b0;
      bus.alloc_warp  = w;
      bus.alloc_nreg  = n;
      bus.alloc_valid = 1'b1;
      for (int t = 0; t < 20; t++) begin
         #1;
         if (bus.alloc_ready) break;
         @(negedge clk);
      end
      @(negedge clk);
      bus.alloc_valid = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (bus.alloc_done) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int done_cyc;
      int done_cnt;
      logic [31:0] exp_sd;
      logic [1:0]  exp_ok;

      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.alloc_valid = 1'b0;
      bus.alloc_warp  = '0;
      bus.alloc_nreg  = '0;
      bus.alloc_swid  = '0;
      bus.exit_valid  = 1'b0;
      bus.exit_warp   = '0;
      bus.rd_warp     = '0;
      bus.rd_src      = '0;
      bus.rd_en       = '0;
      bus.wr_en       = 1'b0;
      bus.wr_warp     = '0;
      bus.wr_reg      = '0;
      bus.oc_empty    = '0;

      repeat (2) @(negedge clk);
      chk("rst_free_slots", bus.free_slots, 16);
      chk("rst_alloc_done", bus.alloc_done, 0);
      chk("rst_alloc_err", bus.alloc_err, 0);
      chk("rst_alloc_ready", bus.alloc_ready, 1);
      rst = 1'b0;
      @(negedge clk);

      // warp 2, nreg 5 -> three grants, done four cycles after accept
      bus.alloc_warp  = 3'd2;
      bus.alloc_nreg  = 4'd5;
      bus.alloc_swid  = 8'hA5;
      bus.alloc_valid = 1'b1;
      #1 chk("a2_ready", bus.alloc_ready, 1);
      done_cyc = 0;
      done_cnt = 0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c == 1) begin
            bus.alloc_valid = 1'b0;
            chk("a2_free_c1", bus.free_slots, 16);
         end
         if (c == 2) chk("a2_free_c2", bus.free_slots, 15);
         if (bus.alloc_done) begin
            done_cnt++;
            done_cyc = c;
         end
      end
      chk("a2_done_cycle", done_cyc, 4);
      chk("a2_done_count", done_cnt, 1);
      chk("a2_free", bus.free_slots, 13);

      // read translation, warp 2 owns slots 0,1,2
      bus.rd_warp = 3'd2;
      bus.rd_en   = 2'b11;
      bus.rd_src  = 8'h13;
      #1;
      chk("rd13_bank", bus.rd_bank, 4'b0111);
      chk("rd13_row", bus.rd_row, 0);
      chk("rd13_ok", bus.rd_ok, 2'b11);
      chk("rd13_conflict", bus.rd_conflict, 0);
      bus.rd_src = 8'h04;
      #1;
      chk("rd04_bank", bus.rd_bank, 0);
      chk("rd04_row", bus.rd_row, 6'd1);
      chk("rd04_conflict", bus.rd_conflict, 1);
      bus.rd_src = 8'h16;
      #1;
      chk("rd16_ok", bus.rd_ok, 2'b10);
      chk("rd16_bank", bus.rd_bank, 4'b0100);
      chk("rd16_conflict", bus.rd_conflict, 0);
      bus.rd_src = 8'h18;
`ifdef RAU_SPECIAL_REG_EN
      exp_ok = 2'b11;
      exp_sd = 32'h0000_00A5;
`else
      exp_ok = 2'b10;
      exp_sd = 32'h0;
`endif
      #1;
      chk("rd_special_ok", bus.rd_ok, exp_ok);
      chk("rd_special_data", bus.special_data, exp_sd);
      bus.rd_en = 2'b00;
      #1;
      chk("rd_disabled_ok", bus.rd_ok, 0);
      chk("rd_disabled_bank", bus.rd_bank, 0);

      // write translation
      bus.wr_en   = 1'b1;
      bus.wr_warp = 3'd2;
      bus.wr_reg  = 3'd5;
      #1;
      chk("wr5_ok", bus.wr_ok, 1);
      chk("wr5_bank", bus.wr_bank, 1);
      chk("wr5_row", bus.wr_row, 1);
      bus.wr_reg = 3'd6;
      #1;
      chk("wr6_ok", bus.wr_ok, 0);
      chk("wr6_bank", bus.wr_bank, 0);
      bus.wr_en  = 1'b0;
      bus.wr_reg = 3'd5;
      #1;
      chk("wr_dis_ok", bus.wr_ok, 0);

      // operand collector select
      bus.oc_empty = 4'b0110;
      #1 chk("oc_0110", bus.oc_sel, 4'b0010);
      bus.oc_empty = 4'b0000;
      #1 chk("oc_0000", bus.oc_sel, 4'b0000);
      bus.oc_empty = 4'b1000;
      #1 chk("oc_1000", bus.oc_sel, 4'b1000);

      // rejected requests: reallocation, nreg 0, need above per-warp limit
      @(negedge clk);
      bus.alloc_warp  = 3'd2;
      bus.alloc_nreg  = 4'd2;
      bus.alloc_valid = 1'b1;
      #1 chk("realloc_ready", bus.alloc_ready, 1);
      @(negedge clk);
      bus.alloc_valid = 1'b0;
      chk("realloc_err", bus.alloc_err, 1);
      chk("realloc_free", bus.free_slots, 13);
      @(negedge clk);
      chk("realloc_err_clear", bus.alloc_err, 0);
      chk("realloc_ready_after", bus.alloc_ready, 1);
      bus.alloc_warp  = 3'd3;
      bus.alloc_nreg  = 4'd0;
      bus.alloc_valid = 1'b1;
      @(negedge clk);
      bus.alloc_valid = 1'b0;
      chk("nreg0_err", bus.alloc_err, 1);
      @(negedge clk);
      bus.alloc_nreg  = 4'd9;
      bus.alloc_valid = 1'b1;
      @(negedge clk);
      bus.alloc_valid = 1'b0;
      chk("nreg9_err", bus.alloc_err, 1);
      chk("nreg9_free", bus.free_slots, 13);
      @(negedge clk);

      // fill down to two free slots
      do_alloc(3'd0, 4'd8, ok);
      chk("fill_w0_done", ok, 1);
      @(negedge clk);
      do_alloc(3'd1, 4'd8, ok);
      chk("fill_w1_done", ok, 1);
      @(negedge clk);
      do_alloc(3'd3, 4'd6, ok);
      chk("fill_w3_done", ok, 1);
      @(negedge clk);
      chk("fill_free", bus.free_slots, 2);

      // insufficient slots: held until warp 2 exits
      bus.alloc_warp  = 3'd4;
      bus.alloc_nreg  = 4'd6;
      bus.alloc_valid = 1'b1;
      #1 chk("short_ready0", bus.alloc_ready, 0);
      @(negedge clk);
      chk("short_ready1", bus.alloc_ready, 0);
      bus.exit_warp  = 3'd2;
      bus.exit_valid = 1'b1;
      @(negedge clk);
      bus.exit_valid = 1'b0;
      #1 chk("short_ready_dealloc", bus.alloc_ready, 0);
      @(negedge clk);
      chk("short_free_after_exit", bus.free_slots, 5);
      chk("short_ready_now", bus.alloc_ready, 1);
      @(negedge clk);
      bus.alloc_valid = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (bus.alloc_done) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("short_done", ok, 1);
      chk("short_free_final", bus.free_slots, 2);
      bus.wr_en   = 1'b1;
      bus.wr_warp = 3'd4;
      bus.wr_reg  = 3'd1;
      #1;
      chk("w4_wr_ok", bus.wr_ok, 1);
      chk("w4_wr_bank", bus.wr_bank, 1);
      chk("w4_wr_row", bus.wr_row, 0);
      bus.rd_warp = 3'd2;
      bus.rd_src  = 8'h01;
      bus.rd_en   = 2'b01;
      #1 chk("w2_freed_rd_ok", bus.rd_ok, 0);
      bus.rd_en = 2'b00;

      // simultaneous exit and alloc: exit first, alloc two cycles later
      @(negedge clk);
      bus.exit_warp   = 3'd0;
      bus.exit_valid  = 1'b1;
      bus.alloc_warp  = 3'd5;
      bus.alloc_nreg  = 4'd2;
      bus.alloc_valid = 1'b1;
      #1 chk("both_ready0", bus.alloc_ready, 0);
      @(negedge clk);
      bus.exit_valid = 1'b0;
      #1 chk("both_ready_dealloc", bus.alloc_ready, 0);
      @(negedge clk);
      chk("both_ready_idle", bus.alloc_ready, 1);
      chk("both_free_after_exit", bus.free_slots, 6);
      @(negedge clk);
      bus.alloc_valid = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (bus.alloc_done) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("both_done", ok, 1);
      chk("both_free_final", bus.free_slots, 5);
      bus.wr_warp = 3'd5;
      bus.wr_reg  = 3'd0;
      #1;
      chk("w5_wr_bank", bus.wr_bank, 2);
      chk("w5_wr_row", bus.wr_row, 1);
      bus.wr_warp = 3'd0;
      #1 chk("w0_freed_wr_ok", bus.wr_ok, 0);

      // exit of an unallocated warp changes nothing
      @(negedge clk);
      bus.exit_warp  = 3'd7;
      bus.exit_valid = 1'b1;
      @(negedge clk);
      bus.exit_valid = 1'b0;
      @(negedge clk);
      chk("noop_exit_free", bus.free_slots, 5);

      // reset in the middle of an allocation
      bus.alloc_warp  = 3'd6;
      bus.alloc_nreg  = 4'd8;
      bus.alloc_valid = 1'b1;
      @(negedge clk);
      bus.alloc_valid = 1'b0;
      @(negedge clk);
      chk("mid_free_one_grant", bus.free_slots, 4);
      rst = 1'b1;
      #1;
      chk("mid_rst_free", bus.free_slots, 16);
      chk("mid_rst_done", bus.alloc_done, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_free", bus.free_slots, 16);
      chk("post_rst_ready", bus.alloc_ready, 1);
      bus.wr_warp = 3'd6;
      bus.wr_reg  = 3'd0;
      #1 chk("post_rst_w6_wr_ok", bus.wr_ok, 0);
      bus.wr_warp = 3'd4;
      bus.wr_reg  = 3'd1;
      #1 chk("post_rst_w4_wr_ok", bus.wr_ok, 0);

      do_alloc(3'd6, 4'd2, ok);
      chk("post_rst_alloc_done", ok, 1);
      @(negedge clk);
      chk("post_rst_alloc_free", bus.free_slots, 15);
      bus.wr_warp = 3'd6;
      bus.wr_reg  = 3'd1;
      #1;
      chk("post_rst_w6_ok", bus.wr_ok, 1);
      chk("post_rst_w6_bank", bus.wr_bank, 1);
      chk("post_rst_w6_row", bus.wr_row, 0);
      bus.wr_en = 1'b0;

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
